// File: rtl/branch_pkg.sv
// branch_pkg: shared types and widths for the branch offset encoder.
//   state_e    : encoder FSM states
//   DIFF_W     : width of the PC-to-target difference (no-wrap width)
//   OFFSET_W   : width of the encoded signed word offset
//   WORD_SHIFT : right shift turning a byte difference into a word offset
package branch_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;
    localparam int DIFF_W     = 33;
    localparam int OFFSET_W   = 16;
    localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/serial_sub_slice.sv
// serial_sub_slice: W-bit combinational ripple-carry adder slice.
//   a, b : addend chunks (caller inverts b to subtract)
//   cin  : carry into bit 0
//   s    : sum chunk
//   cout : carry out of bit W-1
module serial_sub_slice #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    logic [W:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[W];
endmodule

// File: rtl/branch_offset_encoder.sv
// branch_offset_encoder: bit-serial computation of the signed word offset from pc to target.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : request strobe, accepted only while ready
//   pc, target : operands, captured on accept
//   ready      : high in IDLE
//   done       : one-cycle result-valid pulse
//   offset     : encoded offset (truncated when a flag is set), held until next accept
//   overflow   : difference does not fit the offset after the shift
//   misaligned : difference has nonzero bits below the shift
module branch_offset_encoder
    import branch_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1,
    parameter int SHIFT          = WORD_SHIFT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         pc,
    input  logic [31:0]         target,
    output logic                ready,
    output logic                done,
    output logic [OFFSET_W-1:0] offset,
    output logic                overflow,
    output logic                misaligned
);
    localparam int B  = BITS_PER_CYCLE;
    localparam int N  = DIFF_W / B;
    localparam int HI = SHIFT + OFFSET_W - 1;
    localparam logic [DIFF_W-1:0] HI_ONES = {DIFF_W{1'b1}} >> HI;
    localparam logic [DIFF_W-1:0] LO_MASK = (DIFF_W'(1) << SHIFT) - DIFF_W'(1);

    state_e              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [DIFF_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic                carry_q, carry_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic                ovf_q, ovf_d, mis_q, mis_d;
    logic [B-1:0]        sum;
    logic                cout;

    serial_sub_slice #(.W(B)) u_slice (
        .a   (a_q[B-1:0]),
        .b   (~b_q[B-1:0]),
        .cin (carry_q),
        .s   (sum),
        .cout(cout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        carry_d  = carry_q;
        offset_d = offset_q;
        ovf_d    = ovf_q;
        mis_d    = mis_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = {1'b0, target};
                b_d     = {1'b0, pc};
                carry_d = 1'b1;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // new sum chunk enters at the top; after N chunks res_q holds the full difference
                res_d   = DIFF_W'({sum, res_q} >> B);
                a_d     = a_q >> B;
                b_d     = b_q >> B;
                carry_d = cout;
                cnt_d   = cnt_q + 6'd1;
                state_d = (cnt_q == 6'(N - 1)) ? CHECK : RUN;
            end
            CHECK: begin
                mis_d    = |(res_q & LO_MASK);
                // in range only when every bit above the offset's sign bit matches it
                ovf_d    = !(((res_q >> HI) == '0) || ((res_q >> HI) == HI_ONES));
                offset_d = res_q[SHIFT +: OFFSET_W];
                state_d  = DONE;
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            offset_q <= '0;
            ovf_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            offset_q <= offset_d;
            ovf_q    <= ovf_d;
            mis_q    <= mis_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign done       = (state_q == DONE);
    assign offset     = offset_q;
    assign overflow   = ovf_q;
    assign misaligned = mis_q;
endmodule

// File: tb/tb_branch_offset_encoder.sv
// tb_branch_offset_encoder: four encoders (1/3/11/33 bits per cycle) against an arithmetic model.
module tb_branch_offset_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        start = 1'b0;
    logic [31:0] pc = '0, target = '0;
    logic        rdy[4], dn[4], ovf[4], mis[4];
    logic [15:0] off[4];
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        branch_offset_encoder #(.BITS_PER_CYCLE(g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 11 : 33)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .pc        (pc),
            .target    (target),
            .ready     (rdy[g]),
            .done      (dn[g]),
            .offset    (off[g]),
            .overflow  (ovf[g]),
            .misaligned(mis[g])
        );
    end

    function automatic int nchunks(int g);
        return g == 0 ? 33 : g == 1 ? 11 : g == 2 ? 3 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One request; observes cycles accept+1 .. accept+35 so the next call starts right after the slowest done.
    task automatic request(input logic [31:0] p, input logic [31:0] t, input bit poke);
        longint d, w;
        int     first[4], pulses[4];
        d = longint'(t) - longint'(p);
        w = d >>> 2;
        for (int g = 0; g < 4; g++) begin first[g] = 0; pulses[g] = 0; end
        @(negedge clk);
        pc = p; target = t; start = 1'b1;
        for (int j = 1; j <= 35; j++) begin
            @(negedge clk);
            if (j == 1) begin
                start = 1'b0; pc = $urandom; target = $urandom;
                for (int g = 0; g < 4; g++) chk($sformatf("busy%0d", g), rdy[g], 0);
            end
            if (poke && j == 2) begin start = 1'b1; pc = $urandom; target = $urandom; end
            if (poke && j == 3) start = 1'b0;
            for (int g = 0; g < 4; g++)
                if (dn[g]) begin pulses[g]++; if (first[g] == 0) first[g] = j; end
        end
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("lat%0d", g), first[g], nchunks(g) + 2);
            chk($sformatf("pulses%0d", g), pulses[g], 1);
            chk($sformatf("off%0d %h->%h", g, p, t), off[g], 32'(w[15:0]));
            chk($sformatf("ovf%0d %h->%h", g, p, t), ovf[g], (w < -32768 || w > 32767) ? 1 : 0);
            chk($sformatf("mis%0d %h->%h", g, p, t), mis[g], (d & 3) != 0 ? 1 : 0);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("%s_rdy%0d", tag, g), rdy[g], 1);
            chk($sformatf("%s_done%0d", tag, g), dn[g], 0);
            chk($sformatf("%s_off%0d", tag, g), off[g], 0);
            chk($sformatf("%s_ovf%0d", tag, g), ovf[g], 0);
            chk($sformatf("%s_mis%0d", tag, g), mis[g], 0);
        end
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        pc = 32'h0000_2000; target = 32'h0000_3000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_zero("rstmid");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) chk($sformatf("rstnodone%0d", g), dn[g], 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] p, t;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        request(32'h0040_0000, 32'h0040_0010, 0);
        request(32'h0040_0020, 32'h0040_0000, 0);
        request(32'h0001_0000, 32'h0001_0000 + 32'h1FFFC, 0);
        request(32'h0001_0000, 32'h0001_0000 + 32'h20000, 0);
        request(32'h0001_0000, 32'h0001_0000 - 32'h20000, 0);
        request(32'h0001_0000, 32'h0001_0000 - 32'h20004, 0);
        request(32'h0000_1000, 32'h0000_1006, 0);
        request(32'hFFFF_FFFC, 32'h0000_0000, 0);
        request(32'h0000_0000, 32'hFFFF_FFFC, 0);
        request(32'h0040_0000, 32'h0040_0100, 1);
        reset_mid_run();
        request(32'h0000_8000, 32'h0000_7FF4, 0);
        for (int i = 0; i < 24; i++) begin
            p = $urandom;
            t = ($urandom_range(0, 3) != 0) ? p + 32'($urandom_range(0, 32'h4_0007)) - 32'h2_0004 : $urandom;
            request(p, t, i % 5 == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_offset_encoder.md
Name: branch_offset_encoder

Overview:
- Inverse of the branch-target path. Given a current PC and a desired 32-bit target, it computes the signed 16-bit word offset that the sign-extend-plus-add datapath would need to reach that target.
- Flags targets that cannot be encoded: out of range, or not word-aligned.
- Subtraction is bit-serial over a 33-bit two's-complement difference, BITS_PER_CYCLE bits per clock, to keep area at one adder slice.
- Sits beside the assembler/branch-check logic; single request/response handshake.

Parameters:
- BITS_PER_CYCLE, 1, difference bits resolved per clock. Legal values: 1, 3, 11, 33. Must divide 33.
- SHIFT, 2, right shift applied to the difference before narrowing. 2 gives the word offset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request strobe; sampled only when ready=1
- pc  in  32  current PC, unsigned; captured on accept
- target  in  32  desired target, unsigned; captured on accept
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse when the result is valid
- offset  out  16  encoded signed offset; held until next accept
- overflow  out  1  difference does not fit in 16 bits after shift; held
- misaligned  out  1  difference low SHIFT bits nonzero; held

Behaviour:
- Reset (async, active-high): state=IDLE; offset=0, overflow=0, misaligned=0, done=0, carry=0, operand/result shift registers=0. ready=1 as soon as reset asserts.
- Arithmetic: diff[32:0] = {1'b0,target} + ~{1'b0,pc} + 1, two's complement, no truncation. N = 33/BITS_PER_CYCLE.
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE: on start=1, latch the 33-bit operands, set carry=1, clear the chunk counter, go to RUN. If start=0, stay.
- RUN: each cycle, add the low BITS_PER_CYCLE bits of the A and ~B shift registers plus carry. Shift the sum chunk into the top of the result register. Shift the operands right by BITS_PER_CYCLE and register the chunk carry-out. Counter increments. After N RUN cycles go to CHECK.
- CHECK:
  - misaligned = |diff[SHIFT-1:0] (0 when SHIFT=0).
  - overflow = NOT (diff[32:SHIFT+15] all ones or all zeros).
  - offset = diff[SHIFT+15:SHIFT].
  - All three register here. Go to DONE.
- DONE: done=1 for exactly this cycle, then return to IDLE.
- offset is still produced (truncated bits) when overflow=1 or misaligned=1. Consumers must check the flags.
- Latency: accept at edge T; RUN occupies T+1..T+N; CHECK at T+N+1; done high during cycle T+N+2. For BITS_PER_CYCLE=1 this is 35 cycles from accept to done.
- start while ready=0 is ignored; no queueing. pc and target are don't-care except in the accept cycle.
- Back-to-back: start may be asserted in the cycle after done. It is accepted in IDLE.
- Reset mid-operation: abort immediately; all outputs return to reset values; no done pulse.
- Final carry-out of the 33-bit sum is discarded. The 33-bit width guarantees no wrap for any 32-bit unsigned pair.

Decomposition:
- Shared package branch_pkg holds:
  - state enum: IDLE=2'd0, RUN=2'd1, CHECK=2'd2, DONE=2'd3
  - DIFF_W=33
  - OFFSET_W=16
  - WORD_SHIFT=2
- One sub-module: serial_sub_slice.
  - Purely combinational, parameter W, inputs a[W-1:0], b[W-1:0], cin; outputs s[W-1:0], cout.
  - Built as a W-stage full-adder ripple chain; the parent inverts b.
- FSM, counter and registers live in the top module.

Test Plan:
1. pc=0x00400000, target=0x00400010, BITS_PER_CYCLE=1 -> done at accept+35; offset=0x0004, overflow=0, misaligned=0.
2. pc=0x00400020, target=0x00400000 -> offset=0xFFF8, overflow=0, misaligned=0.
3. Range boundaries from pc=0x00010000:
   - target=pc+0x1FFFC -> offset=0x7FFF, overflow=0
   - target=pc+0x20000 -> overflow=1
   - target=pc-0x20000 -> offset=0x8000, overflow=0
   - target=pc-0x20004 -> overflow=1
4. pc=0x00001000, target=0x00001006 -> misaligned=1, offset=0x0001, overflow=0. Separately, pc=0xFFFFFFFC, target=0x00000000 -> overflow=1; diff must not wrap to +4.
5. Assert start again during RUN with different operands -> ignored; first result unchanged. Then assert rst during RUN -> outputs zero immediately, ready=1, no done. Next request completes correctly.
6. Repeat scenarios 1–4 with BITS_PER_CYCLE=3, 11, 33 -> identical results; done at accept+N+2 (N=11, 3, 1). Back-to-back requests with start in the cycle after done are both accepted.
